gspram_sp_sync: RTL

//  Parametrised clocked single-port SRAM model: next generation of the GSPRAM functional models.
//  - Replaces the ena-strobe timing with a clk/req handshake.
//  - Adds per-byte write enables, a selectable read latency, out-of-range detection and an optional

---
 rtl/gspram_sp_sync.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gspram_sp_sync.sv
// Clocked single-port SRAM model with req/rdy handshake, byte write enables,
// 1- or 2-clock read latency, out-of-range flagging and an optional zeroing sweep.

module gspram_sp_sync_lane #(
  parameter int BW = 8,
  parameter int NW = 256,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          xwr,
  input  logic [IW-1:0] idx,
  input  logic [BW-1:0] wd,
  output logic [BW-1:0] rd
);
  logic [BW-1:0] mem [NW];

  // xwr only ever rises in simulation (unknown req); it poisons the whole lane
  always_ff @(posedge clk)
    if (xwr) for (int i = 0; i < NW; i++) mem[i] <= 'x;
    else if (we) mem[idx] <= wd;

  assign rd = mem[idx];
endmodule

module gspram_sp_sync #(
  parameter int WS  = 32,
  parameter int BW  = 8,
  parameter int AW  = 8,
  parameter int NW  = 256,
  parameter int RL  = 1,
  parameter int CLR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             wri,
  input  logic [AW-1:0]    adr,
  input  logic [WS-1:0]    wda,
  input  logic [WS/BW-1:0] bwe,
  output logic [WS-1:0]    rda,
  output logic             rvl,
  output logic             rdy,
  output logic             err
);
  localparam int NB = WS / BW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [AW:0] NW_V = (AW+1)'(NW);

  typedef enum logic {SWEEP, RUN} st_t;
  st_t st, st_nx;

  logic [IW-1:0] swp_cnt;
  logic          swp, swp_we, xreq;
  logic          acc, rd_acc, wr_ok, in_rng;
  logic [IW-1:0] mem_idx;
  logic [NB-1:0] lane_we;
  logic [NB-1:0][BW-1:0] lane_wd, lane_rd;
  logic [WS-1:0] rd_dat, rda_hold;
  logic          wr_err;
  logic [RL:1]   vld_pipe, oor_pipe;
  logic [RL:1][WS-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= (CLR != 0) ? SWEEP : RUN;
    else        st <= st_nx;

  always_comb begin
    st_nx = st;
    case (st)
      SWEEP:   if (swp_cnt == IW'(NW-1)) st_nx = RUN;
      RUN:     st_nx = RUN;
      default: st_nx = st;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    swp = 1'b0;
    case (st)
      SWEEP:   swp = 1'b1;
      RUN:     rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   swp_cnt <= '0;
    else if (swp) swp_cnt <= swp_cnt + 1'b1;

  assign in_rng  = {1'b0, adr} < NW_V;
  assign acc     = req & rdy & rst_n;
  assign rd_acc  = acc & ~wri;
  assign wr_ok   = acc & wri & in_rng;
  assign swp_we  = swp & rst_n;
  assign xreq    = rdy & $isunknown(req);
  assign mem_idx = swp ? swp_cnt : adr[IW-1:0];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lane_we[i] = swp_we | (wr_ok & bwe[i]);
      lane_wd[i] = swp ? '0 : wda[i*BW +: BW];
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    gspram_sp_sync_lane #(.BW(BW), .NW(NW), .IW(IW)) u_lane (
      .clk (clk),
      .we  (lane_we[i]),
      .xwr (xreq),
      .idx (mem_idx),
      .wd  (lane_wd[i]),
      .rd  (lane_rd[i])
    );
  end

  // out-of-range reads return zero rather than whatever the array yields
  assign rd_dat = in_rng ? lane_rd : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      oor_pipe <= '0;
      dat_pipe <= '0;
      rda_hold <= '0;
      wr_err   <= 1'b0;
    end else begin
      vld_pipe <= RL'({vld_pipe, rd_acc});
      oor_pipe <= RL'({oor_pipe, ~in_rng});
      dat_pipe <= (RL*WS)'({dat_pipe, rd_dat});
      rda_hold <= rda;
      wr_err   <= acc & wri & ~in_rng;
    end

  assign rvl = vld_pipe[RL];
  assign rda = vld_pipe[RL] ? dat_pipe[RL] : rda_hold;
  assign err = (vld_pipe[RL] & oor_pipe[RL]) | wr_err;
endmodule
